// File: rtl/color_centroid_if.sv
// Capture-side write stream in, frame-buffer write stream out.
// The centroid block takes the slave view; the camera/bench side takes master.
interface color_centroid_if;
    logic        cap_we;
    logic [12:0] cap_addr;
    logic [11:0] cap_data;
    logic        fb_we;
    logic [12:0] fb_addr;
    logic [11:0] fb_data;

    modport master (
        output cap_we, cap_addr, cap_data,
        input  fb_we, fb_addr, fb_data
    );

    modport slave (
        input  cap_we, cap_addr, cap_data,
        output fb_we, fb_addr, fb_data
    );
endinterface

// File: rtl/color_centroid.sv
// Snoops the capture write stream, forwards it to the frame buffer and computes the red-object centroid.
// Optional build macro COLOR_CENTROID_MARK_EN paints matching pixels green on the frame-buffer path.
module color_centroid #(
    parameter int         c_img_cols    = 80,
    parameter int         c_img_rows    = 60,
    parameter int         c_nb_img_pxls = 13,
    parameter int         c_nb_buf      = 12,
    parameter logic [3:0] c_red_min     = 4'd10,
    parameter logic [3:0] c_oth_max     = 4'd5,
    parameter logic [12:0] c_min_pxls   = 13'd8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rgbmode,
    color_centroid_if.slave      bus,
    output logic                 busy,
    output logic                 obj_valid,
    output logic                 obj_found,
    output logic [12:0]          obj_cnt,
    output logic [6:0]           obj_col,
    output logic [5:0]           obj_row
);
    localparam int c_img_pxls = c_img_cols * c_img_rows;
    localparam logic [4:0] c_last_iter = 5'd18;

    typedef enum logic [1:0] {S_IDLE, S_DIV_COL, S_DIV_ROW, S_DONE} state_t;
    state_t r_state, w_state_next;

    logic                     r_fb_we;
    logic [c_nb_img_pxls-1:0] r_fb_addr;
    logic [c_nb_buf-1:0]      r_fb_data;
    logic [6:0]  r_col;
    logic [5:0]  r_row;
    logic        r_full;
    logic [12:0] r_cnt, r_op_cnt;
    logic [18:0] r_sum_col, r_sum_row, r_op_row;
    logic [18:0] r_quo;
    logic [13:0] r_rem;
    logic [4:0]  r_iter;
    logic [6:0]  r_res_col, r_obj_col;
    logic [5:0]  r_res_row, r_obj_row;
    logic [12:0] r_obj_cnt;
    logic        r_obj_valid, r_obj_found;

    logic        w_match, w_start, w_end, w_pos_ok, w_hit;
    logic [6:0]  w_cur_col;
    logic [5:0]  w_cur_row;
    logic [12:0] w_cnt_next;
    logic [18:0] w_sc_next, w_sr_next;
    logic [13:0] w_rem_shift, w_rem_new;
    logic [18:0] w_quo_new;
    logic        w_ge;

    assign w_match  = rgbmode & (bus.cap_data[11:8] >= c_red_min)
                    & (bus.cap_data[7:4] <= c_oth_max) & (bus.cap_data[3:0] <= c_oth_max);
    assign w_start  = bus.cap_we & (bus.cap_addr == '0);
    assign w_end    = bus.cap_we & (bus.cap_addr == 13'(c_img_pxls - 1));
    // A restart at address 0 overrides the running position and the overflow guard.
    assign w_cur_col = w_start ? 7'd0 : r_col;
    assign w_cur_row = w_start ? 6'd0 : r_row;
    assign w_pos_ok  = w_start | ~r_full;
    assign w_hit     = bus.cap_we & w_match & w_pos_ok;

    assign w_cnt_next = (w_start ? 13'd0 : r_cnt) + 13'(w_hit);
    assign w_sc_next  = (w_start ? 19'd0 : r_sum_col) + (w_hit ? 19'(w_cur_col) : 19'd0);
    assign w_sr_next  = (w_start ? 19'd0 : r_sum_row) + (w_hit ? 19'(w_cur_row) : 19'd0);

    // One restoring-division step: r_quo shifts dividend bits out and quotient bits in.
    assign w_rem_shift = {r_rem[12:0], r_quo[18]};
    assign w_ge        = (w_rem_shift >= {1'b0, r_op_cnt});
    assign w_rem_new   = w_ge ? (w_rem_shift - {1'b0, r_op_cnt}) : w_rem_shift;
    assign w_quo_new   = {r_quo[17:0], w_ge};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_end) w_state_next = (w_cnt_next == '0) ? S_DONE : S_DIV_COL;
            S_DIV_COL: if (r_iter == c_last_iter) w_state_next = S_DIV_ROW;
            S_DIV_ROW: if (r_iter == c_last_iter) w_state_next = S_DONE;
            S_DONE:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fb_we <= 1'b0;  r_fb_addr <= '0;  r_fb_data <= '0;
            r_col <= '0;  r_row <= '0;  r_full <= 1'b0;
            r_cnt <= '0;  r_sum_col <= '0;  r_sum_row <= '0;
            r_op_cnt <= '0;  r_op_row <= '0;  r_quo <= '0;  r_rem <= '0;  r_iter <= '0;
            r_res_col <= '0;  r_res_row <= '0;
            r_obj_valid <= 1'b0;  r_obj_found <= 1'b0;  r_obj_cnt <= '0;
            r_obj_col <= '0;  r_obj_row <= '0;
        end else begin
            r_fb_we   <= bus.cap_we;
            r_fb_addr <= bus.cap_addr;
`ifdef COLOR_CENTROID_MARK_EN
            r_fb_data <= w_match ? 12'h0F0 : bus.cap_data;
`else
            r_fb_data <= bus.cap_data;
`endif
            r_cnt     <= w_cnt_next;
            r_sum_col <= w_sc_next;
            r_sum_row <= w_sr_next;

            if (bus.cap_we && w_pos_ok) begin
                r_full <= 1'b0;
                if (w_cur_col == 7'(c_img_cols - 1)) begin
                    r_col <= '0;
                    if (w_cur_row == 6'(c_img_rows - 1)) r_full <= 1'b1;
                    else                                 r_row  <= w_cur_row + 6'd1;
                end else begin
                    r_col <= w_cur_col + 7'd1;
                    r_row <= w_cur_row;
                end
            end

            r_obj_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (w_end) begin
                    r_op_cnt  <= w_cnt_next;
                    r_op_row  <= w_sr_next;
                    r_quo     <= w_sc_next;
                    r_rem     <= '0;
                    r_iter    <= '0;
                    r_res_col <= '0;
                    r_res_row <= '0;
                end
                S_DIV_COL: begin
                    r_rem  <= w_rem_new;
                    r_quo  <= w_quo_new;
                    r_iter <= r_iter + 5'd1;
                    if (r_iter == c_last_iter) begin
                        r_res_col <= w_quo_new[6:0];
                        r_quo     <= r_op_row;
                        r_rem     <= '0;
                        r_iter    <= '0;
                    end
                end
                S_DIV_ROW: begin
                    r_rem  <= w_rem_new;
                    r_quo  <= w_quo_new;
                    r_iter <= r_iter + 5'd1;
                    if (r_iter == c_last_iter) begin
                        r_res_row <= w_quo_new[5:0];
                        r_iter    <= '0;
                    end
                end
                S_DONE: begin
                    r_obj_valid <= 1'b1;
                    r_obj_cnt   <= r_op_cnt;
                    r_obj_col   <= r_res_col;
                    r_obj_row   <= r_res_row;
                    r_obj_found <= (r_op_cnt >= c_min_pxls);
                end
                default: ;
            endcase
        end
    end

    assign bus.fb_we   = r_fb_we;
    assign bus.fb_addr = r_fb_addr;
    assign bus.fb_data = r_fb_data;
    assign busy        = (r_state == S_DIV_COL) || (r_state == S_DIV_ROW);
    assign obj_valid   = r_obj_valid;
    assign obj_found   = r_obj_found;
    assign obj_cnt     = r_obj_cnt;
    assign obj_col     = r_obj_col;
    assign obj_row     = r_obj_row;
endmodule

// File: tb/tb_color_centroid.sv
// Scoreboard bench for color_centroid: pass-through stream and per-frame centroid results.
module tb_color_centroid;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rgbmode = 1'b0;
    logic        busy, obj_valid, obj_found;
    logic [12:0] obj_cnt;
    logic [6:0]  obj_col;
    logic [5:0]  obj_row;

    color_centroid_if bus ();

    color_centroid dut (
        .clk(clk), .rst(rst), .rgbmode(rgbmode), .bus(bus),
        .busy(busy), .obj_valid(obj_valid), .obj_found(obj_found),
        .obj_cnt(obj_cnt), .obj_col(obj_col), .obj_row(obj_row)
    );

    initial forever #5 clk = ~clk;

    typedef struct { logic [12:0] a; logic [11:0] d; } fb_exp_t;
    typedef struct { int due; int cnt; int col; int row; bit found; } obj_exp_t;
    fb_exp_t  fb_q[$];
    obj_exp_t obj_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int neg_cnt  = 0;
    int m_cnt = 0, m_sc = 0, m_sr = 0;

    function automatic bit is_match(input logic [11:0] d, input logic mode);
        return mode && (d[11:8] >= 4'd10) && (d[7:4] <= 4'd5) && (d[3:0] <= 4'd5);
    endfunction

    function automatic logic [11:0] exp_fb(input logic [11:0] d, input logic mode);
`ifdef COLOR_CENTROID_MARK_EN
        if (is_match(d, mode)) return 12'h0F0;
`endif
        return d;
    endfunction

    function automatic logic [11:0] pattern(input int kind, input int a);
        int c, r;
        c = a % 80;
        r = a / 80;
        case (kind)
            0: return 12'h000;
            1: return (c >= 20 && c <= 23 && r >= 10 && r <= 13) ? 12'hF00 : 12'h888;
            2: return (a == 4799) ? 12'hF00 : 12'h888;
            3: return 12'h888;
            default: return 12'hF00;
        endcase
    endfunction

    // Output monitor: stream and result scoreboards, sampled mid-cycle.
    always @(negedge clk) begin
        fb_exp_t  fe;
        obj_exp_t oe;
        neg_cnt = neg_cnt + 1;
        if (!rst) begin
            n_checks++;
            if (fb_q.size() > 0) begin
                fe = fb_q.pop_front();
                if (bus.fb_we !== 1'b1 || bus.fb_addr !== fe.a || bus.fb_data !== fe.d) begin
                    n_errors++;
                    $display("FAIL fb_stream: got we=%b addr=%0d data=%h, want we=1 addr=%0d data=%h",
                             bus.fb_we, bus.fb_addr, bus.fb_data, fe.a, fe.d);
                end
            end else if (bus.fb_we !== 1'b0) begin
                n_errors++;
                $display("FAIL fb_idle: got fb_we=%b, want 0", bus.fb_we);
            end
            if (obj_valid === 1'b1) begin
                n_checks++;
                if (obj_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL obj_unexpected: got obj_valid=1, want 0");
                end else begin
                    oe = obj_q.pop_front();
                    if (neg_cnt != oe.due || obj_cnt !== 13'(oe.cnt) || obj_col !== 7'(oe.col) ||
                        obj_row !== 6'(oe.row) || obj_found !== oe.found) begin
                        n_errors++;
                        $display("FAIL obj_result: got cyc=%0d cnt=%0d col=%0d row=%0d found=%b, want cyc=%0d cnt=%0d col=%0d row=%0d found=%b",
                                 neg_cnt, obj_cnt, obj_col, obj_row, obj_found,
                                 oe.due, oe.cnt, oe.col, oe.row, oe.found);
                    end else
                        $display("result ok: cnt=%0d col=%0d row=%0d found=%b", obj_cnt, obj_col, obj_row, obj_found);
                end
            end else if (obj_q.size() > 0 && neg_cnt > obj_q[0].due) begin
                oe = obj_q.pop_front();
                n_checks++;
                n_errors++;
                $display("FAIL obj_timeout: got no obj_valid by cyc %0d, want it at cyc %0d", neg_cnt, oe.due);
            end
        end
    end

    task automatic write_px(input int a, input logic [11:0] d);
        obj_exp_t oe;
        bus.cap_we   = 1'b1;
        bus.cap_addr = 13'(a);
        bus.cap_data = d;
        @(posedge clk);
        fb_q.push_back('{13'(a), exp_fb(d, rgbmode)});
        if (a == 0) begin
            m_cnt = 0; m_sc = 0; m_sr = 0;
        end
        if (is_match(d, rgbmode)) begin
            m_cnt++; m_sc += a % 80; m_sr += a / 80;
        end
        if (a == 4799) begin
            oe.due   = neg_cnt + ((m_cnt == 0) ? 2 : 40);
            oe.cnt   = m_cnt;
            oe.col   = (m_cnt == 0) ? 0 : m_sc / m_cnt;
            oe.row   = (m_cnt == 0) ? 0 : m_sr / m_cnt;
            oe.found = (m_cnt >= 8);
            obj_q.push_back(oe);
        end
        #1;
    endtask

    task automatic write_frame(input int kind, input int first, input int last);
        for (int a = first; a <= last; a++) write_px(a, pattern(kind, a));
    endtask

    task automatic go_idle();
        bus.cap_we = 1'b0;
    endtask

    task automatic wait_results();
        for (int i = 0; i < 100 && obj_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        go_idle();
        bus.cap_addr = '0;
        bus.cap_data = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.fb_we, bus.fb_addr, bus.fb_data, busy, obj_valid, obj_found, obj_cnt, obj_col, obj_row} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got fb_we=%b busy=%b valid=%b found=%b cnt=%0d col=%0d row=%0d, want all 0",
                     bus.fb_we, busy, obj_valid, obj_found, obj_cnt, obj_col, obj_row);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_zero_frame();
        rgbmode = 1'b1;
        write_frame(0, 0, 4799);
        go_idle();
        wait_results();
        $display("test_zero_frame done");
    endtask

    task automatic test_block();
        int nb;
        nb = 0;
        write_frame(1, 0, 4799);
        go_idle();
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (busy === 1'b1) nb++;
        end
        n_checks++;
        if (nb != 38) begin
            n_errors++;
            $display("FAIL busy_cycles: got %0d, want 38", nb);
        end
        wait_results();
        $display("test_block done: busy cycles %0d", nb);
    endtask

    task automatic test_mid_reset();
        write_frame(1, 0, 4799);
        go_idle();
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        obj_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, obj_valid, obj_found, obj_cnt, obj_col, obj_row} !== '0) begin
            n_errors++;
            $display("FAIL mid_reset: got busy=%b valid=%b found=%b cnt=%0d col=%0d row=%0d, want all 0",
                     busy, obj_valid, obj_found, obj_cnt, obj_col, obj_row);
        end
        repeat (50) @(negedge clk);
        @(posedge clk); #1;
        $display("test_mid_reset done");
    endtask

    task automatic test_single_pixel();
        write_frame(2, 0, 4799);
        go_idle();
        wait_results();
        $display("test_single_pixel done");
    endtask

    task automatic test_restart();
        write_frame(1, 0, 1500);
        write_frame(3, 0, 4799);
        go_idle();
        wait_results();
        $display("test_restart done");
    endtask

    task automatic test_rgbmode();
        rgbmode = 1'b0;
        write_frame(4, 0, 4799);
        go_idle();
        wait_results();
        rgbmode = 1'b1;
        write_frame(4, 0, 4799);
        go_idle();
        wait_results();
        $display("test_rgbmode done");
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish by 3 ms, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cap_we   = 1'b0;
        bus.cap_addr = '0;
        bus.cap_data = '0;
        test_reset();
        test_zero_frame();
        test_block();
        test_mid_reset();
        test_single_pixel();
        test_restart();
        test_rgbmode();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
